// File: rtl/sb_param_cfgbuf_pkg.sv
// Shared types and constants for the parametrised switch block with a double-buffered config chain.
// Frame length depends on SB_CFG_PARITY_EN (adds one even-parity bit at the chain LSB).
package sb_cfg_pkg;

   typedef enum logic [1:0] {
      SIDE_T = 2'd0,
      SIDE_R = 2'd1,
      SIDE_B = 2'd2,
      SIDE_L = 2'd3
   } side_e;

   localparam int NUM_SIDES = int'(SIDE_L) + 1;

   localparam logic [1:0] SEL_LEFT     = 2'd0;
   localparam logic [1:0] SEL_STRAIGHT = 2'd1;
   localparam logic [1:0] SEL_RIGHT    = 2'd2;
   localparam logic [1:0] SEL_PIN      = 2'd3;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } cfg_state_e;

   function automatic int cfg_bits(input int chan_w);
      return 2 * NUM_SIDES * chan_w;
   endfunction

   function automatic int frame_bits(input int chan_w);
`ifdef SB_CFG_PARITY_EN
      return cfg_bits(chan_w) + 1;
`else
      return cfg_bits(chan_w);
`endif
   endfunction

   // Side feeding a track mux input for a given select (not valid for SEL_PIN).
   function automatic int src_side(input int side, input logic [1:0] sel);
      return (side + 1 + int'(sel)) % NUM_SIDES;
   endfunction

endpackage

// File: rtl/sb_track_mux4.sv
// One 4:1 routing mux for a single output track; data order follows the SEL_* encoding.
module sb_track_mux4
   import sb_cfg_pkg::*;
(
   input  logic [3:0] data,
   input  logic [1:0] sel,
   output logic       y
);

   always_comb begin
      y = 1'b0;
      case (sel)
         SEL_LEFT:     y = data[0];
         SEL_STRAIGHT: y = data[1];
         SEL_RIGHT:    y = data[2];
         SEL_PIN:      y = data[3];
         default:      y = 1'b0;
      endcase
   end

endmodule

// File: rtl/sb_param_cfgbuf.sv
// Four-sided switch block whose mux selects are double-buffered: a shadow scan chain loads,
// a commit copies it atomically into the active register. SB_CFG_PARITY_EN adds frame parity.
module sb_param_cfgbuf
   import sb_cfg_pkg::*;
#(
   parameter int CHAN_W = 5,
   parameter int NPIN   = 1
)
(
   input  logic                  prog_clk,
   input  logic                  pReset,
   input  logic                  ccff_head,
   input  logic                  cfg_shift_en,
   input  logic                  cfg_commit,
   output logic                  ccff_tail,
   output logic                  cfg_done,
   output logic                  cfg_valid,
   output logic                  cfg_err,
   input  logic [4*CHAN_W-1:0]   chan_in,
   input  logic [4*NPIN-1:0]     pin_in,
   output logic [4*CHAN_W-1:0]   chan_out
);

   localparam int CFG_BITS   = cfg_bits(CHAN_W);
   localparam int FRAME_BITS = frame_bits(CHAN_W);
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   cfg_state_e              state_reg, state_next;
   logic [FRAME_BITS-1:0]   shadow_reg, shadow_next;
   logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
   logic [CFG_BITS-1:0]     active_reg, active_next;
   logic                    cfg_valid_reg, cfg_valid_next;
   logic                    cfg_err_reg;

   logic                    parity_ok;
   logic [CFG_BITS-1:0]     frame_cfg;
   logic                    commit_accept;
   logic                    commit_reject;
   logic                    done_comb;

   // Parity is the last bit shifted (LSB); the select bits sit above it.
`ifdef SB_CFG_PARITY_EN
   assign parity_ok = ~(^shadow_reg);
   assign frame_cfg = shadow_reg[FRAME_BITS-1:1];
`else
   assign parity_ok = 1'b1;
   assign frame_cfg = shadow_reg;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         state_reg <= ST_EMPTY;
      end else begin
         state_reg <= state_next;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_EMPTY: begin
            if (cfg_shift_en) state_next = ST_PARTIAL;
         end
         ST_PARTIAL: begin
            if (cfg_shift_en && (bit_cnt_reg == CNT_LAST)) state_next = ST_FULL;
         end
         ST_FULL: begin
            // A shift alongside an accepted commit starts the next frame at one bit.
            if (commit_accept) state_next = cfg_shift_en ? ST_PARTIAL : ST_EMPTY;
         end
         default: state_next = ST_EMPTY;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      done_comb     = 1'b0;
      commit_accept = 1'b0;
      commit_reject = 1'b0;
      case (state_reg)
         ST_FULL: begin
            done_comb     = 1'b1;
            commit_accept = cfg_commit & parity_ok;
            commit_reject = cfg_commit & ~parity_ok;
         end
         default: begin
            commit_reject = cfg_commit;
         end
      endcase
   end

   // ---------------- datapath next-state ----------------
   always_comb begin
      shadow_next    = shadow_reg;
      bit_cnt_next   = bit_cnt_reg;
      active_next    = active_reg;
      cfg_valid_next = cfg_valid_reg;

      if (cfg_shift_en) begin
         shadow_next = {shadow_reg[FRAME_BITS-2:0], ccff_head};
      end

      if (commit_accept) begin
         active_next    = frame_cfg;
         cfg_valid_next = 1'b1;
         bit_cnt_next   = cfg_shift_en ? CNT_ONE : '0;
      end else if (cfg_shift_en && (bit_cnt_reg != CNT_FULL)) begin
         bit_cnt_next = bit_cnt_reg + CNT_ONE;
      end
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         shadow_reg    <= '0;
         bit_cnt_reg   <= '0;
         active_reg    <= '0;
         cfg_valid_reg <= 1'b0;
         cfg_err_reg   <= 1'b0;
      end else begin
         shadow_reg    <= shadow_next;
         bit_cnt_reg   <= bit_cnt_next;
         active_reg    <= active_next;
         cfg_valid_reg <= cfg_valid_next;
         cfg_err_reg   <= commit_reject;
      end
   end

   assign ccff_tail = shadow_reg[FRAME_BITS-1];
   assign cfg_done  = done_comb;
   assign cfg_valid = cfg_valid_reg;
   assign cfg_err   = cfg_err_reg;

   // ---------------- routing muxes ----------------
   genvar gi, gj;
   generate
      for (gi = 0; gi < NUM_SIDES; gi++) begin : g_side
         for (gj = 0; gj < CHAN_W; gj++) begin : g_track
            localparam int K = gi * CHAN_W + gj;
            logic [3:0] mux_data;
            logic       mux_y;

            assign mux_data = {
               pin_in[gi*NPIN + (gj % NPIN)],
               chan_in[src_side(gi, SEL_RIGHT)    * CHAN_W + gj],
               chan_in[src_side(gi, SEL_STRAIGHT) * CHAN_W + gj],
               chan_in[src_side(gi, SEL_LEFT)     * CHAN_W + gj]
            };

            sb_track_mux4 u_mux (
               .data (mux_data),
               .sel  (active_reg[2*K+1:2*K]),
               .y    (mux_y)
            );

            // Outputs stay quiet until a configuration has actually been loaded.
            assign chan_out[K] = mux_y & cfg_valid_reg;
         end
      end
   endgenerate

endmodule

// File: tb/tb_sb_param_cfgbuf.sv
// Directed bench for sb_param_cfgbuf (CHAN_W=5, NPIN=1); table of routing vectors plus
// hand-written sequences for commit/shift corner cases. Parity sequence under SB_CFG_PARITY_EN.
module tb_sb_param_cfgbuf;

   localparam int CW  = 5;
   localparam int NP  = 1;
   localparam int CFG = 8 * CW;
`ifdef SB_CFG_PARITY_EN
   localparam int FRAME = CFG + 1;
`else
   localparam int FRAME = CFG;
`endif

   logic              prog_clk = 1'b0;
   logic              pReset;
   logic              ccff_head;
   logic              cfg_shift_en;
   logic              cfg_commit;
   logic              ccff_tail;
   logic              cfg_done;
   logic              cfg_valid;
   logic              cfg_err;
   logic [4*CW-1:0]   chan_in;
   logic [4*NP-1:0]   pin_in;
   logic [4*CW-1:0]   chan_out;

   int total = 0;
   int bad   = 0;

   sb_param_cfgbuf #(.CHAN_W(CW), .NPIN(NP)) dut (
      .prog_clk     (prog_clk),
      .pReset       (pReset),
      .ccff_head    (ccff_head),
      .cfg_shift_en (cfg_shift_en),
      .cfg_commit   (cfg_commit),
      .ccff_tail    (ccff_tail),
      .cfg_done     (cfg_done),
      .cfg_valid    (cfg_valid),
      .cfg_err      (cfg_err),
      .chan_in      (chan_in),
      .pin_in       (pin_in),
      .chan_out     (chan_out)
   );

   always #5 prog_clk = ~prog_clk;

   typedef struct {
      logic [39:0] cfg;
      logic [19:0] chan;
      logic [3:0]  pin;
      logic [19:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge prog_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   function automatic logic [FRAME-1:0] make_frame(input logic [CFG-1:0] c);
`ifdef SB_CFG_PARITY_EN
      return {c, ^c};
`else
      return c;
`endif
   endfunction

   // Shift frame bits hi down to lo, one per cycle (MSB of the frame goes first).
   task automatic shift_range(input logic [FRAME-1:0] f, input int hi, input int lo);
      for (int i = hi; i >= lo; i--) begin
         ccff_head    = f[i];
         cfg_shift_en = 1'b1;
         tick();
      end
      cfg_shift_en = 1'b0;
      ccff_head    = 1'b0;
   endtask

   task automatic commit_pulse();
      cfg_commit = 1'b1;
      tick();
      cfg_commit = 1'b0;
   endtask

   task automatic load_cfg(input logic [CFG-1:0] c);
      shift_range(make_frame(c), FRAME - 1, 0);
      commit_pulse();
   endtask

   initial begin
      logic [FRAME-1:0] f;
      logic [FRAME-1:0] f2;
      logic [39:0]      loaded;

      vecs[0] = '{40'h00_0000_0000, 20'h00020, 4'h0, 20'h00001};
      vecs[1] = '{40'h00_0000_0000, 20'h00001, 4'hF, 20'h08000};
      vecs[2] = '{40'h00_0000_0000, 20'h003FF, 4'h0, 20'hF801F};
      vecs[3] = '{40'hAA_AAAA_AAAA, 20'h00001, 4'h0, 20'h00020};
      vecs[4] = '{40'hAA_AAAA_AAAA, 20'h08000, 4'h0, 20'h00001};
      vecs[5] = '{40'hFF_FFFF_FFFF, 20'hFFFFF, 4'h5, 20'h07C1F};
      vecs[6] = '{40'hFF_FFFF_FFFF, 20'h00000, 4'h8, 20'hF8000};
      vecs[7] = '{40'h00_0000_0003, 20'h00040, 4'h1, 20'h00003};
      vecs[8] = '{40'h55_5555_5555, 20'h01000, 4'h0, 20'h00004};
      vecs[9] = '{40'h55_5555_5555, 20'h0001F, 4'hF, 20'h07C00};

      pReset       = 1'b1;
      ccff_head    = 1'b0;
      cfg_shift_en = 1'b0;
      cfg_commit   = 1'b0;
      chan_in      = '1;
      pin_in       = '1;
      tick();
      tick();
      check("rst_chan_out", 64'(chan_out), 64'h0);
      check("rst_valid",    64'(cfg_valid), 64'h0);
      check("rst_done",     64'(cfg_done), 64'h0);
      check("rst_err",      64'(cfg_err), 64'h0);
      check("rst_tail",     64'(ccff_tail), 64'h0);
      pReset = 1'b0;
      tick();

      // Commit with an empty shadow is rejected with a single-cycle error
      commit_pulse();
      check("empty_commit_err", 64'(cfg_err), 64'h1);
      check("empty_commit_valid", 64'(cfg_valid), 64'h0);
      tick();
      check("empty_commit_err_clear", 64'(cfg_err), 64'h0);

      // Test 1: all-zero frame, T t0 follows R t0
      f = make_frame('0);
      shift_range(f, FRAME - 1, 0);
      check("t1_done", 64'(cfg_done), 64'h1);
      check("t1_tail", 64'(ccff_tail), 64'h0);
      commit_pulse();
      check("t1_valid", 64'(cfg_valid), 64'h1);
      check("t1_done_clear", 64'(cfg_done), 64'h0);
      check("t1_err", 64'(cfg_err), 64'h0);
      chan_in = 20'h00020;
      pin_in  = 4'h0;
      #1;
      check("t1_route", 64'(chan_out), 64'h1);
      loaded = 40'h00_0000_0000;

      // Routing table
      for (int i = 0; i < 10; i++) begin
         if (vecs[i].cfg != loaded) begin
            load_cfg(vecs[i].cfg);
            loaded = vecs[i].cfg;
         end
         chan_in = vecs[i].chan;
         pin_in  = vecs[i].pin;
         #1;
         check($sformatf("vec%0d_chan_out", i), 64'(chan_out), 64'(vecs[i].exp));
      end

      // Test 3: partial frame commit rejected, active config (straight) kept
      f = make_frame(40'hAA_AAAA_AAAA);
      shift_range(f, FRAME - 1, FRAME - 10);
      commit_pulse();
      check("t3_err", 64'(cfg_err), 64'h1);
      check("t3_valid", 64'(cfg_valid), 64'h1);
      chan_in = 20'h01000;
      pin_in  = 4'h0;
      #1;
      check("t3_active_kept", 64'(chan_out), 64'h00004);
      tick();
      check("t3_err_one_cycle", 64'(cfg_err), 64'h0);
      shift_range(f, FRAME - 11, 1);
      check("t3_done_early", 64'(cfg_done), 64'h0);
      shift_range(f, 0, 0);
      check("t3_done_exact", 64'(cfg_done), 64'h1);
      check("t3_tail", 64'(ccff_tail), 64'h1);
      commit_pulse();
      chan_in = 20'h00001;
      #1;
      check("t3_new_route", 64'(chan_out), 64'h00020);

      // Test 4: commit and shift in the same cycle
      f = make_frame(40'hFF_FFFF_FFFF);
      shift_range(f, FRAME - 1, 0);
      f2 = make_frame('0);
      ccff_head    = f2[FRAME-1];
      cfg_shift_en = 1'b1;
      cfg_commit   = 1'b1;
      tick();
      cfg_shift_en = 1'b0;
      cfg_commit   = 1'b0;
      check("t4_done", 64'(cfg_done), 64'h0);
      check("t4_err", 64'(cfg_err), 64'h0);
      chan_in = 20'h00000;
      pin_in  = 4'h5;
      #1;
      check("t4_route", 64'(chan_out), 64'h07C1F);
      shift_range(f2, FRAME - 2, 1);
      check("t4_cnt_one_less", 64'(cfg_done), 64'h0);
      shift_range(f2, 0, 0);
      check("t4_cnt_full", 64'(cfg_done), 64'h1);
      commit_pulse();
      chan_in = 20'h003FF;
      pin_in  = 4'h0;
      #1;
      check("t4_second_route", 64'(chan_out), 64'hF801F);

      // Test 5: reset in the middle of a shift
      f = make_frame(40'h55_5555_5555);
      shift_range(f, FRAME - 1, FRAME - 19);
      ccff_head    = f[FRAME-20];
      cfg_shift_en = 1'b1;
      pReset       = 1'b1;
      tick();
      pReset       = 1'b0;
      cfg_shift_en = 1'b0;
      chan_in      = '1;
      pin_in       = '1;
      #1;
      check("t5_chan_out", 64'(chan_out), 64'h0);
      check("t5_valid", 64'(cfg_valid), 64'h0);
      check("t5_done", 64'(cfg_done), 64'h0);
      check("t5_tail", 64'(ccff_tail), 64'h0);
      check("t5_err", 64'(cfg_err), 64'h0);
      f = make_frame(40'hAA_AAAA_AAAA);
      shift_range(f, FRAME - 1, 0);
      check("t5_reload_done", 64'(cfg_done), 64'h1);
      commit_pulse();
      check("t5_reload_valid", 64'(cfg_valid), 64'h1);
      chan_in = 20'h00001;
      pin_in  = 4'h0;
      #1;
      check("t5_reload_route", 64'(chan_out), 64'h00020);

`ifdef SB_CFG_PARITY_EN
      // Test 6: bad parity rejected, then corrected frame loads
      f = {40'h00_0000_0003, ~(^40'h00_0000_0003)};
      shift_range(f, FRAME - 1, 0);
      check("t6_done", 64'(cfg_done), 64'h1);
      commit_pulse();
      check("t6_err", 64'(cfg_err), 64'h1);
      check("t6_done_kept", 64'(cfg_done), 64'h1);
      chan_in = 20'h00001;
      pin_in  = 4'h1;
      #1;
      check("t6_active_kept", 64'(chan_out), 64'h00020);
      tick();
      check("t6_err_clear", 64'(cfg_err), 64'h0);
      load_cfg(40'h00_0000_0003);
      chan_in = 20'h00000;
      pin_in  = 4'h1;
      #1;
      check("t6_good_route", 64'(chan_out), 64'h00001);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
